// File: rtl/seq_checker_pkg.sv
// Shared encodings for the symbol-stream protocol: protocol states, per-state symbols,
// tracker control states and a saturating counter helper.
package seq_checker_pkg;

    typedef enum logic [2:0] {
        ST_Z = 3'd0,
        ST_T = 3'd1,
        ST_V = 3'd2,
        ST_H = 3'd3,
        ST_X = 3'd4,
        ST_F = 3'd5
    } proto_st_e;

    typedef enum logic {
        CTL_HUNT   = 1'b0,
        CTL_LOCKED = 1'b1
    } ctl_st_e;

    localparam logic [2:0] SYM_Z = 3'd2;
    localparam logic [2:0] SYM_T = 3'd6;
    localparam logic [2:0] SYM_V = 3'd5;
    localparam logic [2:0] SYM_H = 3'd5;
    localparam logic [2:0] SYM_X = 3'd6;
    localparam logic [2:0] SYM_F = 3'd4;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == CNT_MAX) ? v : v + 8'd1;
    endfunction

    // Only the F and Z symbols are unique to one state; both are always followed by T.
    function automatic logic is_resync_sym(input logic [2:0] s);
        return (s == SYM_F) || (s == SYM_Z);
    endfunction

endpackage

// File: rtl/seq_checker_if.sv
// Symbol-stream observation bus between the generator side and the checker.
interface seq_checker_if;
    logic       en;
    logic       a;
    logic [2:0] sym;
    logic       lock;
    logic       err;
    logic [2:0] expected;
    logic [7:0] loop_cnt;
    logic [7:0] err_cnt;

    modport master (
        output en, a, sym,
        input  lock, err, expected, loop_cnt, err_cnt
    );

    modport slave (
        input  en, a, sym,
        output lock, err, expected, loop_cnt, err_cnt
    );
endinterface

// File: rtl/seq_checker_cyc_step.sv
// Combinational protocol step: next state and emitted symbol for a given state and branch input.
// Zero latency, no flow control.
module cyc_step
    import seq_checker_pkg::*;
(
    input  proto_st_e  state,
    input  logic       a,
    output proto_st_e  nxt_state,
    output logic [2:0] symbol
);

    always_comb begin
        nxt_state = ST_Z;
        symbol    = SYM_Z;
        case (state)
            ST_Z: begin nxt_state = ST_T;                symbol = SYM_Z; end
            ST_T: begin nxt_state = ST_V;                symbol = SYM_T; end
            ST_V: begin nxt_state = a ? ST_H : ST_X;     symbol = SYM_V; end
            ST_H: begin nxt_state = ST_X;                symbol = SYM_H; end
            ST_X: begin nxt_state = ST_F;                symbol = SYM_X; end
            ST_F: begin nxt_state = ST_T;                symbol = SYM_F; end
            default: begin nxt_state = ST_Z;             symbol = SYM_Z; end
        endcase
    end

endmodule

// File: rtl/seq_checker.sv
// Tracks a generator's symbol stream, flags mismatches and resynchronises on unique symbols.
// lock/err/counters update one clock after a sampled symbol; en=0 stalls everything.
module seq_checker
    import seq_checker_pkg::*;
(
    input  logic          clk,
    input  logic          res,
    seq_checker_if.slave  io
);

    proto_st_e  trk_q, trk_d;
    ctl_st_e    ctl_q, ctl_d;
    logic       lock_q, lock_d;
    logic       err_q, err_d;
    logic [7:0] loop_cnt_q, loop_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    proto_st_e  step_nxt;
    logic [2:0] exp_sym;
    logic       sym_match;

    cyc_step u_cyc_step (
        .state     (trk_q),
        .a         (io.a),
        .nxt_state (step_nxt),
        .symbol    (exp_sym)
    );

    assign sym_match = (io.sym == exp_sym);

    always_comb begin
        trk_d      = trk_q;
        ctl_d      = ctl_q;
        lock_d     = lock_q;
        err_d      = 1'b0;
        loop_cnt_d = loop_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (io.en) begin
            if (ctl_q == CTL_LOCKED) begin
                if (sym_match) begin
                    trk_d  = step_nxt;
                    lock_d = 1'b1;
                    // A match in F means the 4 closing a loop was seen.
                    if (trk_q == ST_F) begin
                        loop_cnt_d = sat_inc(loop_cnt_q);
                    end
                end else begin
                    err_d     = 1'b1;
                    err_cnt_d = sat_inc(err_cnt_q);
                    ctl_d     = CTL_HUNT;
                    lock_d    = 1'b0;
                end
            end else if (is_resync_sym(io.sym)) begin
                trk_d  = ST_T;
                ctl_d  = CTL_LOCKED;
                lock_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            trk_q      <= ST_Z;
            ctl_q      <= CTL_LOCKED;
            lock_q     <= 1'b0;
            err_q      <= 1'b0;
            loop_cnt_q <= 8'd0;
            err_cnt_q  <= 8'd0;
        end else begin
            trk_q      <= trk_d;
            ctl_q      <= ctl_d;
            lock_q     <= lock_d;
            err_q      <= err_d;
            loop_cnt_q <= loop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign io.lock     = lock_q;
    assign io.err      = err_q;
    assign io.expected = exp_sym;
    assign io.loop_cnt = loop_cnt_q;
    assign io.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_seq_checker.sv
// Scoreboard bench for seq_checker: directed symbol streams with hand-computed responses.
module tb_seq_checker;

    logic clk = 1'b0;
    logic res;

    seq_checker_if bus ();

    seq_checker dut (
        .clk (clk),
        .res (res),
        .io  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       lock;
        logic       err;
        logic [2:0] expv;
        logic [7:0] loops;
        logic [7:0] errs;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // Monitor: one prediction per clocked symbol, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.tag, ".lock"},     8'(bus.lock),     8'(e.lock));
            chk({e.tag, ".err"},      8'(bus.err),      8'(e.err));
            chk({e.tag, ".expected"}, 8'(bus.expected), 8'(e.expv));
            chk({e.tag, ".loop_cnt"}, bus.loop_cnt,     e.loops);
            chk({e.tag, ".err_cnt"},  bus.err_cnt,      e.errs);
        end
    end

    task automatic step(input logic e_in, input logic a_in, input logic [2:0] s_in,
                        input string tag, input logic l, input logic er,
                        input logic [2:0] x, input logic [7:0] lc, input logic [7:0] ec);
        exp_t e;
        @(negedge clk);
        bus.en  = e_in;
        bus.a   = a_in;
        bus.sym = s_in;
        e.tag   = tag;
        e.lock  = l;
        e.err   = er;
        e.expv  = x;
        e.loops = lc;
        e.errs  = ec;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        bus.en = 1'b0;
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s.drain actual=%0d required=0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".lock"},     8'(bus.lock),     8'd0);
        chk({tag, ".err"},      8'(bus.err),      8'd0);
        chk({tag, ".expected"}, 8'(bus.expected), 8'd2);
        chk({tag, ".loop_cnt"}, bus.loop_cnt,     8'd0);
        chk({tag, ".err_cnt"},  bus.err_cnt,      8'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        bus.en = 1'b0;
        res    = 1'b0;
        #1;
        check_reset_vals(tag);
        @(negedge clk);
        res = 1'b1;
    endtask

    function automatic logic [7:0] sat8(input int v);
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res     = 1'b0;
        bus.en  = 1'b0;
        bus.a   = 1'b0;
        bus.sym = 3'd0;
        #2;
        check_reset_vals("por");

        // Plain loops with a=0: Z T V X F T V X F
        do_reset("rst1");
        step(1, 0, 3'd2, "t1s0", 1, 0, 3'd6, 8'd0, 8'd0);
        step(1, 0, 3'd6, "t1s1", 1, 0, 3'd5, 8'd0, 8'd0);
        step(1, 0, 3'd5, "t1s2", 1, 0, 3'd6, 8'd0, 8'd0);
        step(1, 0, 3'd6, "t1s3", 1, 0, 3'd4, 8'd0, 8'd0);
        step(1, 0, 3'd4, "t1s4", 1, 0, 3'd6, 8'd1, 8'd0);
        step(1, 0, 3'd6, "t1s5", 1, 0, 3'd5, 8'd1, 8'd0);
        step(1, 0, 3'd5, "t1s6", 1, 0, 3'd6, 8'd1, 8'd0);
        step(1, 0, 3'd6, "t1s7", 1, 0, 3'd4, 8'd1, 8'd0);
        step(1, 0, 3'd4, "t1s8", 1, 0, 3'd6, 8'd2, 8'd0);
        drain("t1");

        // Branch through H with a=1 on the V cycle
        do_reset("rst2");
        step(1, 0, 3'd2, "t2s0", 1, 0, 3'd6, 8'd0, 8'd0);
        step(1, 0, 3'd6, "t2s1", 1, 0, 3'd5, 8'd0, 8'd0);
        step(1, 1, 3'd5, "t2s2", 1, 0, 3'd5, 8'd0, 8'd0);
        step(1, 0, 3'd5, "t2s3", 1, 0, 3'd6, 8'd0, 8'd0);
        step(1, 0, 3'd6, "t2s4", 1, 0, 3'd4, 8'd0, 8'd0);
        step(1, 0, 3'd4, "t2s5", 1, 0, 3'd6, 8'd1, 8'd0);

        // Mismatch at F, hunt through ambiguous symbols, resync on 4
        step(1, 0, 3'd6, "t3s0", 1, 0, 3'd5, 8'd1, 8'd0);
        step(1, 0, 3'd5, "t3s1", 1, 0, 3'd6, 8'd1, 8'd0);
        step(1, 0, 3'd6, "t3s2", 1, 0, 3'd4, 8'd1, 8'd0);
        step(1, 0, 3'd6, "t3err", 0, 1, 3'd4, 8'd1, 8'd1);
        step(1, 0, 3'd5, "t3h0", 0, 0, 3'd4, 8'd1, 8'd1);
        step(1, 0, 3'd6, "t3h1", 0, 0, 3'd4, 8'd1, 8'd1);
        step(1, 0, 3'd4, "t3rs", 1, 0, 3'd6, 8'd1, 8'd1);

        // Invalid symbol while locked, stall right after the error, ambiguous hunt, resync on 2
        step(1, 0, 3'd3, "t4err", 0, 1, 3'd6, 8'd1, 8'd2);
        step(0, 0, 3'd4, "t4stl", 0, 0, 3'd6, 8'd1, 8'd2);
        step(1, 0, 3'd5, "t4h0", 0, 0, 3'd6, 8'd1, 8'd2);
        step(1, 0, 3'd6, "t4h1", 0, 0, 3'd6, 8'd1, 8'd2);
        step(1, 0, 3'd5, "t4h2", 0, 0, 3'd6, 8'd1, 8'd2);
        step(1, 0, 3'd2, "t4rs", 1, 0, 3'd6, 8'd1, 8'd2);

        // Five stalled cycles with random inputs mid-stream
        step(1, 0, 3'd6, "t5s0", 1, 0, 3'd5, 8'd1, 8'd2);
        for (int i = 0; i < 5; i++) begin
            step(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 "t5hold", 1, 0, 3'd5, 8'd1, 8'd2);
        end
        step(1, 0, 3'd5, "t5s1", 1, 0, 3'd6, 8'd1, 8'd2);
        step(1, 0, 3'd6, "t5s2", 1, 0, 3'd4, 8'd1, 8'd2);
        step(1, 0, 3'd4, "t5s3", 1, 0, 3'd6, 8'd2, 8'd2);
        drain("t5");

        // loop_cnt saturation over 257 loops
        do_reset("rst6");
        step(1, 0, 3'd2, "t6s0", 1, 0, 3'd6, 8'd0, 8'd0);
        for (int k = 1; k <= 257; k++) begin
            step(1, 0, 3'd6, "t6t", 1, 0, 3'd5, sat8(k - 1), 8'd0);
            step(1, 0, 3'd5, "t6v", 1, 0, 3'd6, sat8(k - 1), 8'd0);
            step(1, 0, 3'd6, "t6x", 1, 0, 3'd4, sat8(k - 1), 8'd0);
            step(1, 0, 3'd4, "t6f", 1, 0, 3'd6, sat8(k), 8'd0);
        end
        drain("t6");

        // err_cnt saturation over 300 mismatch/resync pairs
        do_reset("rst7");
        for (int k = 1; k <= 300; k++) begin
            step(1, 0, 3'd7, "t7err", 0, 1, (k == 1) ? 3'd2 : 3'd6, 8'd0, sat8(k));
            step(1, 0, 3'd2, "t7rs",  1, 0, 3'd6, 8'd0, sat8(k));
        end
        drain("t7");

        // Asynchronous reset pulse between clock edges
        @(posedge clk);
        #3;
        res = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge clk);
        res = 1'b1;
        step(1, 0, 3'd2, "t8s0", 1, 0, 3'd6, 8'd0, 8'd0);
        step(1, 0, 3'd6, "t8s1", 1, 0, 3'd5, 8'd0, 8'd0);
        drain("t8");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port res, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port en, input, 1, symbol-valid strobe; all state holds when 0.
REQ-004 SHALL have port a, input, 1, branch control applied to the generator in the same cycle.
REQ-005 SHALL have port sym, input, 3, observed generator output symbol.
REQ-006 SHALL have port lock, output, 1, tracker synchronized to the stream.
REQ-007 SHALL have port err, output, 1, one-cycle pulse on a mismatch while locked.
REQ-008 SHALL have port expected, output, 3, symbol predicted for the current cycle.
REQ-009 SHALL have port loop_cnt, output, 8, completed loops, saturating.
REQ-010 SHALL have port err_cnt, output, 8, mismatches, saturating.

Function
REQ-011 SHALL track the protocol states Z, T, V, H, X and F.
REQ-012 SHALL use these symbols per state: Z=2, T=6, V=5, H=5, X=6, F=4.
REQ-013 SHALL use these protocol transitions: Z->T, T->V, V->H if a=1 else X, H->X, X->F, F->T.
REQ-014 SHALL implement control FSM states HUNT and LOCKED; after reset it is LOCKED with tracked state Z.
REQ-015 SHALL drive expected = symbol(tracked state) combinationally from registered state.
REQ-016 In LOCKED with en=1 and sym==expected: SHALL advance the tracked state per REQ-013 using a from the same cycle; lock stays 1.
REQ-017 In LOCKED with en=1 and sym!=expected: SHALL assert err for exactly the next cycle, increment err_cnt, enter HUNT, and set lock=0 at the next edge.
REQ-018 Invalid symbols 0, 1, 3 and 7 while LOCKED SHALL be mismatches per REQ-017.
REQ-019 In HUNT with en=1, sym=4 or sym=2: SHALL set the tracked state to T, enter LOCKED, and set lock=1 at the next edge.
REQ-020 In HUNT, any other symbol SHALL leave the block in HUNT with no err and no count change, because 5 and 6 are ambiguous.
REQ-021 SHALL increment loop_cnt when LOCKED, en=1, tracked state F, and sym==4; the resync in REQ-019 SHALL NOT count.
REQ-022 loop_cnt and err_cnt SHALL saturate at 255 and never wrap.
REQ-023 With en=0: state, counters and lock SHALL hold, and err SHALL be 0.
REQ-024 Latency: lock, err and the counters SHALL update one clock after the sampled symbol; expected SHALL reflect the new state in that same cycle.
REQ-025 First cycle after reset, with lock=0 (REQ-033): sym=2 SHALL be a match and set lock=1; any other symbol SHALL be a mismatch per REQ-017.

Reset
REQ-026 res=0 SHALL immediately, independent of clk, force: tracked state Z, control state LOCKED, lock=0, err=0, loop_cnt=0, err_cnt=0, expected=2.
REQ-027 Reset asserted mid-stream SHALL discard the tracked state.
REQ-028 After reset deassertion, the first en=1 edge SHALL be treated as the first symbol.

Structure
REQ-029 SHALL place the protocol state encodings (3-bit), the symbol constants and the HUNT/LOCKED encodings in a shared package reused by the generator-side blocks.
REQ-030 SHALL place the combinational protocol next-state/symbol function in one sub-module, cyc_step: inputs state and a; outputs next state and symbol.
REQ-031 All flops SHALL be asynchronous-clear on res.

REQ-032 Note, ambiguity between REQ-014 and REQ-026: after reset, lock=0 while the control state is LOCKED.
REQ-033 The case in REQ-032 SHALL be resolved as follows: lock is registered and rises on the first matching symbol.

Verification
REQ-034 Bench SHALL cover: reset, then en=1, a=0, sym 2,6,5,6,4,6,5,6,4 -> lock=1 after the first edge, err never 1, loop_cnt=2.
REQ-035 Bench SHALL cover: reset, then a=1 on the V cycles, sym 2,6,5,5,6,4 -> no err, loop_cnt=1; expected reads 2,6,5,5,6,4.
REQ-036 Bench SHALL cover: locked, expected=4, sym=6 -> err=1 for one cycle, err_cnt=1, lock=0; then sym 5,6,4 -> lock=1 after the 4, expected=6.
REQ-037 Bench SHALL cover: sym=3 while locked -> err pulse; in HUNT, sym 5,6,5 -> no err and err_cnt unchanged.
REQ-038 Bench SHALL cover: en=0 for 5 cycles mid-stream with random sym -> all outputs held, err=0; resuming matches without error.
REQ-039 Bench SHALL cover: 300 forced mismatch/resync pairs -> err_cnt=255 saturated; res pulse between edges -> all outputs zero and expected=2 immediately.
